abro_n_tracker: RTL and testbench
=================================

ABRO_N_TRACKER -- requirements
Module: abro_n_tracker

Interface
REQ-001 Parameter N, default 4: number of event channels, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of the fire counter.
REQ-003 Parameter AUTO_REARM, default 0: 0 selects one-shot (wait for R after fire); 1 selects automatic rearm after fire.
REQ-004 Parameter TIMEOUT, default 16: cycles allowed in COLLECT before abort, legal range 2..65535; used only with ABRO_TIMEOUT_EN.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ev  input  N  per-channel event strobes, level-sampled each cycle.
REQ-008 R  input  1  restart request, sampled each cycle.
REQ-009 O  output  1  one-cycle fire pulse, registered.
REQ-010 seen  output  N  registered per-channel latched-event bits.
REQ-011 done  output  1  high while in DONE.
REQ-012 count  output  CNT_W  number of fires since reset, saturating.
REQ-013 timeout  output  1  one-cycle abort pulse; present only when ABRO_TIMEOUT_EN is defined.

Function
REQ-014 The block SHALL implement four states: IDLE (seen all zero), COLLECT (seen partial), FIRE, DONE.
REQ-015 The merged vector nxt = seen | ev SHALL be evaluated in IDLE and COLLECT each cycle.
REQ-016 From IDLE or COLLECT: nxt all ones -> FIRE with seen cleared; nxt nonzero but not all ones -> COLLECT with seen=nxt; nxt zero -> stay in IDLE.
REQ-017 Channel events SHALL latch in any order, across any number of cycles; repeated events on an already-seen channel have no effect.
REQ-018 O SHALL equal 1 exactly in the FIRE cycle: final event sampled on edge t, O high from t to t+1, one cycle only.
REQ-019 count SHALL increment by 1 on every entry to FIRE and hold at 2^CNT_W-1 once reached (no wrap).
REQ-020 From FIRE: AUTO_REARM=0 -> DONE; AUTO_REARM=1 -> IDLE; ev sampled during FIRE SHALL be ignored.
REQ-021 In DONE, ev SHALL be ignored, seen stays zero, and done=1 until R is sampled.
REQ-022 R sampled high in IDLE, COLLECT or DONE SHALL go to IDLE with seen cleared and take priority over any simultaneous ev, including a completing ev.
REQ-023 R sampled in FIRE SHALL NOT truncate the O pulse; the next state is IDLE in either mode.
REQ-024 count SHALL NOT be affected by R.

Reset
REQ-025 reset sampled high SHALL set state=IDLE, seen=0, O=0, done=0, count=0, timeout=0 (if present), and timeout counter=0.
REQ-026 reset SHALL take priority over R, ev and any in-progress sequence, including in the FIRE cycle.

Configuration
REQ-027 With macro ABRO_TIMEOUT_EN defined, a 16-bit cycle counter SHALL clear on entry to COLLECT and increment each cycle spent in COLLECT.
REQ-028 With ABRO_TIMEOUT_EN defined, if the counter reaches TIMEOUT-1 in COLLECT without completion, the block SHALL go to IDLE, clear seen, and pulse timeout for one cycle.
REQ-029 With ABRO_TIMEOUT_EN defined, completion or R in the expiry cycle SHALL win over timeout: no timeout pulse.
REQ-030 Without ABRO_TIMEOUT_EN, the timeout port and counter SHALL be absent and COLLECT SHALL wait indefinitely.

Verification
REQ-031 N=4, AUTO_REARM=0: ev=0001, 0100, 1000, 0010 on four consecutive cycles -> O=1 one cycle after the 0010 sample, then done=1, count=1.
REQ-032 N=4: single cycle with ev=1111 from IDLE -> O pulse next cycle; further ev=1111 in DONE -> no O, count stays 1; R -> IDLE, seen=0000.
REQ-033 AUTO_REARM=1: ev=1111 held high for 6 cycles -> O pattern 1,0,1,0,1,0 (FIRE then IDLE alternating), count=3.
REQ-034 seen=0111 in COLLECT, same cycle ev=1000 and R=1 -> IDLE, seen=0000, no O; R during FIRE -> O still one full cycle.
REQ-035 CNT_W=2, AUTO_REARM=1: 5 fires -> count sequence 1,2,3,3,3.
REQ-036 ABRO_TIMEOUT_EN, TIMEOUT=4: ev=0001 then idle -> timeout pulse 4 cycles after COLLECT entry, seen=0000; rerun with completion in expiry cycle -> O=1, timeout=0.

Source files
------------

// File: rtl/abro_n_tracker.sv
// abro_n_tracker: N-channel ABRO-style event tracker.
// Each channel's event is latched until every channel has been seen, then a
// one-cycle fire pulse O is issued and the saturating fire counter advances.
// After a fire the block waits in DONE for R (AUTO_REARM=0), or goes straight
// back to IDLE (AUTO_REARM=1). R restarts the collection from any waiting state.
//
// Optional feature macro: ABRO_TIMEOUT_EN
//   When defined, a COLLECT phase that does not complete within TIMEOUT cycles
//   is abandoned, seen is cleared and a one-cycle timeout pulse is emitted.
//   When undefined, the timeout port and its counter do not exist.
module abro_n_tracker #(
  parameter int N          = 4,
  parameter int CNT_W      = 8,
  parameter int AUTO_REARM = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     ev,
  input  logic             R,
  output logic             O,
  output logic [N-1:0]     seen,
  output logic             done,
  output logic [CNT_W-1:0] count
`ifdef ABRO_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FIRE    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [N-1:0] ALL_SEEN = {N{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     merged;
  logic [N-1:0]     seen_nxt;
  logic             fire_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             expire;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

`ifdef ABRO_TIMEOUT_EN
  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

  logic [15:0] tcnt;
  logic [15:0] tcnt_nxt;
  logic        timeout_nxt;

  // Expiry is only meaningful while collecting; it loses to R and completion.
  assign expire = (state == S_COLLECT) && (tcnt == T_LAST);

  // Age of the current COLLECT phase: zero on entry, +1 per cycle held there.
  always_comb begin
    tcnt_nxt = 16'd0;
    if ((state == S_COLLECT) && (state_nxt == S_COLLECT)) begin
      tcnt_nxt = tcnt + 16'd1;
    end
  end

  // A timeout pulse is issued only when the expiry path was actually taken.
  assign timeout_nxt = expire && !R && (merged != ALL_SEEN);

  // Timeout counter and pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt    <= 16'd0;
      timeout <= 1'b0;
    end else begin
      tcnt    <= tcnt_nxt;
      timeout <= timeout_nxt;
    end
  end
`else
  // The TIMEOUT parameter has no effect when the timeout feature is absent.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT);
  assign expire = 1'b0;
`endif

  assign merged = seen | ev;

  // Next-state, next-seen and fire decision for the tracker.
  always_comb begin
    state_nxt = state;
    seen_nxt  = seen;
    fire_nxt  = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (R) begin
          // Restart wins over everything, including a completing event.
          state_nxt = S_IDLE;
          seen_nxt  = '0;
        end else if (merged == ALL_SEEN) begin
          state_nxt = S_FIRE;
          seen_nxt  = '0;
          fire_nxt  = 1'b1;
        end else if (expire) begin
          state_nxt = S_IDLE;
          seen_nxt  = '0;
        end else if (merged != '0) begin
          state_nxt = S_COLLECT;
          seen_nxt  = merged;
        end else begin
          state_nxt = S_IDLE;
          seen_nxt  = '0;
        end
      end
      S_FIRE: begin
        // Events arriving during the fire cycle are discarded.
        seen_nxt = '0;
        if (R || (AUTO_REARM != 0)) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        seen_nxt = '0;
        if (R) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        seen_nxt  = '0;
      end
    endcase
  end

  // Fire count advances on every entry into FIRE and is untouched by R.
  always_comb begin
    count_nxt = count;
    if (fire_nxt) begin
      count_nxt = sat_inc(count);
    end
  end

  // State, latched-event and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      seen  <= '0;
      O     <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      seen  <= seen_nxt;
      O     <= fire_nxt;
      count <= count_nxt;
    end
  end

  assign done = (state == S_DONE);

endmodule

// File: tb/tb_abro_n_tracker.sv
// Bench for abro_n_tracker: two instances (one-shot with wide counter, and
// auto-rearm with a 2-bit counter) share stimulus; each is checked every
// cycle against a behavioural model, plus literal checks on directed cases.
module tb_abro_n_tracker;

`ifdef ABRO_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  localparam int TMO = 4;

  logic       clk;
  logic       reset;
  logic [3:0] ev;
  logic       R;

  logic       o0, o1, done0, done1;
  logic [3:0] seen0, seen1;
  logic [7:0] count0;
  logic [1:0] count1;
`ifdef ABRO_TIMEOUT_EN
  logic       to0, to1;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  abro_n_tracker #(.N(4), .CNT_W(8), .AUTO_REARM(0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .reset(reset), .ev(ev), .R(R),
    .O(o0), .seen(seen0), .done(done0), .count(count0)
`ifdef ABRO_TIMEOUT_EN
    , .timeout(to0)
`endif
  );

  abro_n_tracker #(.N(4), .CNT_W(2), .AUTO_REARM(1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .reset(reset), .ev(ev), .R(R),
    .O(o1), .seen(seen1), .done(done1), .count(count1)
`ifdef ABRO_TIMEOUT_EN
    , .timeout(to1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Abstract model: the set of channels seen so far, whether a fire is being
  // reported, whether the tracker is parked waiting for R, and bookkeeping.
  typedef struct packed {
    logic [3:0] seen;
    logic       fire;
    logic       halt;
    logic       to;
    int         cnt;
    int         age;
  } ms_t;

  ms_t m0, m1;

  function automatic ms_t mstep(ms_t s, logic [3:0] e, bit r, bit rst, bit ar, int cmax);
    ms_t n;
    logic [3:0] m;
    n = s;
    n.fire = 1'b0;
    n.to = 1'b0;
    if (rst) begin
      n.seen = 4'h0; n.halt = 1'b0; n.cnt = 0; n.age = 0;
      return n;
    end
    if (s.fire) begin
      n.seen = 4'h0;
      n.halt = !r && !ar;
      n.age = 0;
    end else if (s.halt) begin
      n.seen = 4'h0;
      if (r) n.halt = 1'b0;
    end else if (r) begin
      n.seen = 4'h0;
      n.age = 0;
    end else begin
      m = s.seen | e;
      if (m == 4'hF) begin
        n.fire = 1'b1;
        n.seen = 4'h0;
        n.age = 0;
        if (s.cnt < cmax) n.cnt = s.cnt + 1;
      end else if (TEN && (s.seen != 4'h0) && (s.age == TMO - 1)) begin
        n.seen = 4'h0;
        n.to = 1'b1;
        n.age = 0;
      end else begin
        n.seen = m;
        n.age = (s.seen == 4'h0) ? 0 : s.age + 1;
      end
    end
    return n;
  endfunction

  // Model advances on the same edge as the DUT, from the same sampled inputs.
  always @(posedge clk) begin
    m0 = mstep(m0, ev, R, reset, 1'b0, 255);
    m1 = mstep(m1, ev, R, reset, 1'b1, 3);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("d0.O", 32'(o0), 32'(m0.fire));
      check("d0.seen", 32'(seen0), 32'(m0.seen));
      check("d0.done", 32'(done0), 32'(m0.halt));
      check("d0.count", 32'(count0), 32'(m0.cnt));
      check("d1.O", 32'(o1), 32'(m1.fire));
      check("d1.seen", 32'(seen1), 32'(m1.seen));
      check("d1.done", 32'(done1), 32'(m1.halt));
      check("d1.count", 32'(count1), 32'(m1.cnt));
`ifdef ABRO_TIMEOUT_EN
      check("d0.timeout", 32'(to0), 32'(m0.to));
      check("d1.timeout", 32'(to1), 32'(m1.to));
`endif
    end
  end

  task automatic tick(input logic [3:0] e, input logic r);
    ev = e;
    R = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ev = 4'h0;
    R = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ev = 4'h0;
    R = 1'b0;
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;

    check("rst.count", 32'(count0), 32'd0);
    check("rst.seen", 32'(seen0), 32'd0);
    check("rst.O", 32'(o0), 32'd0);
    check("rst.done", 32'(done0), 32'd0);

    // Events in arbitrary order over four cycles.
    tick(4'b0001, 1'b0);
    tick(4'b0100, 1'b0);
    tick(4'b1000, 1'b0);
    check("seq.seen", 32'(seen0), 32'b1101);
    tick(4'b0010, 1'b0);
    check("seq.O", 32'(o0), 32'd1);
    check("seq.count", 32'(count0), 32'd1);
    tick(4'b0000, 1'b0);
    check("seq.done", 32'(done0), 32'd1);
    check("seq.Olow", 32'(o0), 32'd0);

    // Events in DONE are ignored; R returns to IDLE.
    tick(4'b1111, 1'b0);
    check("done.O", 32'(o0), 32'd0);
    check("done.count", 32'(count0), 32'd1);
    tick(4'b0000, 1'b1);
    check("rrst.done", 32'(done0), 32'd0);
    check("rrst.seen", 32'(seen0), 32'd0);

    // Single all-ones cycle fires; R during FIRE keeps the pulse.
    tick(4'b1111, 1'b0);
    check("one.O", 32'(o0), 32'd1);
    check("one.count", 32'(count0), 32'd2);
    ev = 4'h0;
    R = 1'b1;
    #1;
    check("rfire.Ohold", 32'(o0), 32'd1);
    @(negedge clk);
    check("rfire.Oend", 32'(o0), 32'd0);
    check("rfire.idle", 32'(done0), 32'd0);

    // R beats a completing event.
    tick(4'b0111, 1'b0);
    check("rwin.pre", 32'(seen0), 32'b0111);
    tick(4'b1000, 1'b1);
    check("rwin.O", 32'(o0), 32'd0);
    check("rwin.seen", 32'(seen0), 32'd0);
    tick(4'b0000, 1'b0);

    // Auto-rearm pattern and 2-bit saturation on instance 1.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      tick(4'b1111, 1'b0);
      check("ar.O", 32'(o1), 32'(i % 2));
      check("ar.count", 32'(count1), 32'((i + 1) / 2 > 3 ? 3 : (i + 1) / 2));
    end
    check("ar.d0count", 32'(count0), 32'd1);
    check("ar.d0done", 32'(done0), 32'd1);

    // Reset in the fire cycle.
    tick(4'b1111, 1'b0);
    check("rstfire.pre", 32'(o1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstfire.O", 32'(o1), 32'd0);
    check("rstfire.count", 32'(count1), 32'd0);
    check("rstfire.count0", 32'(count0), 32'd0);
    reset = 1'b0;

`ifdef ABRO_TIMEOUT_EN
    // Abort after TMO cycles in COLLECT.
    tick(4'b0001, 1'b0);
    for (int i = 0; i < TMO - 1; i++) begin
      tick(4'b0000, 1'b0);
      check("tmo.wait", 32'(to0), 32'd0);
    end
    tick(4'b0000, 1'b0);
    check("tmo.pulse", 32'(to0), 32'd1);
    check("tmo.seen", 32'(seen0), 32'd0);
    tick(4'b0000, 1'b0);
    check("tmo.once", 32'(to0), 32'd0);
    // Completion in the expiry cycle wins.
    tick(4'b0001, 1'b0);
    for (int i = 0; i < TMO - 1; i++) tick(4'b0000, 1'b0);
    tick(4'b1110, 1'b0);
    check("tmo.winO", 32'(o0), 32'd1);
    check("tmo.winT", 32'(to0), 32'd0);
    tick(4'b0000, 1'b1);
`endif

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      R = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) ev = 4'($urandom);
      else ev = 4'($urandom) & 4'($urandom) & 4'($urandom);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
